// File: rtl/core_result_monitor.sv
// Purpose: watches the core's PC and data-memory stores, then latches a done/pass verdict, failure cause and cycle count.
// Latency: the verdict registers on the halt edge or the timeout edge, and a store on that same edge is folded into the verdict.
// Backpressure: none. This is a passive observer, and once a verdict is reached it ignores further activity until reset.
module core_result_monitor #(
   parameter int                 DATA_W      = 32,
   parameter int                 ADDR_W      = 32,
   parameter logic [ADDR_W-1:0]  RESULT_ADDR = '0,
   parameter logic [DATA_W-1:0]  EXPECTED    = '0,
   parameter int                 TIMEOUT     = 4096,
   parameter int                 HALT_REPEAT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              done,
   output logic              pass,
   output logic [1:0]        fail_code,
   output logic              result_seen,
   output logic [DATA_W-1:0] result_value,
   output logic [31:0]       cycle_count
);

   typedef enum logic [1:0] {ST_RUN, ST_PASS, ST_FAIL} state_t;

   localparam logic [1:0] FC_NONE     = 2'b00;
   localparam logic [1:0] FC_MISMATCH = 2'b01;
   localparam logic [1:0] FC_TIMEOUT  = 2'b10;
   localparam logic [1:0] FC_NOSIG    = 2'b11;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              pc_vld_q, pc_vld_d;
   logic [31:0]       same_cnt_q, same_cnt_d;
   logic [31:0]       cycle_count_q, cycle_count_d;
   logic              result_seen_q, result_seen_d;
   logic [DATA_W-1:0] result_value_q, result_value_d;
   logic [1:0]        fail_code_q, fail_code_d;

   logic              sig_hit;
   logic              same_pc;
   logic              halt;
   logic              timeout;
   logic              eff_seen;
   logic [DATA_W-1:0] eff_val;
   logic [31:0]       cnt_inc;

   // Decode the events of this edge: signature store, repeated PC, halt and timeout.
   always_comb begin
      sig_hit  = mem_we && (mem_addr == RESULT_ADDR);
      same_pc  = pc_vld_q && (pc == pc_q);
      halt     = same_pc && ((same_cnt_q + 32'd1) == 32'(HALT_REPEAT));
      cnt_inc  = (cycle_count_q == 32'hFFFF_FFFF) ? cycle_count_q : cycle_count_q + 32'd1;
      timeout  = (cnt_inc == 32'(TIMEOUT));
      // A store on this edge takes precedence over the held signature.
      eff_seen = sig_hit || result_seen_q;
      eff_val  = sig_hit ? mem_wdata : result_value_q;
   end

   // Next-state logic. Halt is checked before timeout, so halt wins when both occur on the same edge.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc;
      pc_vld_d       = 1'b1;
      same_cnt_d     = same_cnt_q;
      cycle_count_d  = cycle_count_q;
      result_seen_d  = result_seen_q;
      result_value_d = result_value_q;
      fail_code_d    = fail_code_q;
      if (state_q == ST_RUN) begin
         cycle_count_d = cnt_inc;
         same_cnt_d    = same_pc ? same_cnt_q + 32'd1 : 32'd0;
         if (sig_hit) begin
            result_value_d = mem_wdata;
            result_seen_d  = 1'b1;
         end
         if (halt) begin
            if (!eff_seen) begin
               state_d     = ST_FAIL;
               fail_code_d = FC_NOSIG;
            end else if (eff_val == EXPECTED) begin
               state_d     = ST_PASS;
               fail_code_d = FC_NONE;
            end else begin
               state_d     = ST_FAIL;
               fail_code_d = FC_MISMATCH;
            end
         end else if (timeout) begin
            state_d     = ST_FAIL;
            fail_code_d = FC_TIMEOUT;
         end
      end
   end

   // State registers. An asynchronous reset clears them all immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= ST_RUN;
         pc_q           <= '0;
         pc_vld_q       <= 1'b0;
         same_cnt_q     <= '0;
         cycle_count_q  <= '0;
         result_seen_q  <= 1'b0;
         result_value_q <= '0;
         fail_code_q    <= FC_NONE;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         pc_vld_q       <= pc_vld_d;
         same_cnt_q     <= same_cnt_d;
         cycle_count_q  <= cycle_count_d;
         result_seen_q  <= result_seen_d;
         result_value_q <= result_value_d;
         fail_code_q    <= fail_code_d;
      end
   end

   assign done         = (state_q != ST_RUN);
   assign pass         = (state_q == ST_PASS);
   assign fail_code    = fail_code_q;
   assign result_seen  = result_seen_q;
   assign result_value = result_value_q;
   assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_core_result_monitor.sv
// Purpose: directed bench for core_result_monitor covering the pass, mismatch, no-signature, timeout, same-edge and mid-run reset cases.
// Latency: inputs are driven 1 time unit after a rising edge, and outputs are sampled 1 time unit after the next rising edge.
// Backpressure: not applicable. Every scenario runs for a fixed number of edges.
module tb_core_result_monitor;

   localparam logic [31:0] RA = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc = '0;
   logic        mem_we = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;

   logic        a_done, a_pass, a_seen, b_done, b_pass, b_seen;
   logic [1:0]  a_fc, b_fc;
   logic [31:0] a_val, a_cnt, b_val, b_cnt;
   logic [68:0] a_vec, b_vec;

   int n_cmp = 0;
   int n_fail = 0;

   assign a_vec = {a_done, a_pass, a_fc, a_seen, a_val, a_cnt};
   assign b_vec = {b_done, b_pass, b_fc, b_seen, b_val, b_cnt};

   always #5 clk = ~clk;

   core_result_monitor #(.RESULT_ADDR(RA), .EXPECTED(32'd0), .TIMEOUT(4096), .HALT_REPEAT(4)) u_a (
      .clk(clk), .reset(reset), .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .done(a_done), .pass(a_pass), .fail_code(a_fc), .result_seen(a_seen),
      .result_value(a_val), .cycle_count(a_cnt));

   core_result_monitor #(.RESULT_ADDR(RA), .EXPECTED(32'd0), .TIMEOUT(16), .HALT_REPEAT(4)) u_b (
      .clk(clk), .reset(reset), .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .done(b_done), .pass(b_pass), .fail_code(b_fc), .result_seen(b_seen),
      .result_value(b_val), .cycle_count(b_cnt));

   // Each vector is packed as {done, pass, fail_code, result_seen, result_value, cycle_count}.
   task automatic step(input logic [31:0] p, input logic we, input logic [31:0] a, input logic [31:0] d);
      pc = p; mem_we = we; mem_addr = a; mem_wdata = d;
      @(posedge clk);
      #1;
   endtask

   // Hold reset across one edge, then release it between edges so that the next edge is RUN edge 1.
   task automatic do_reset;
      pc = '0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
      reset = 1'b0;
      @(posedge clk);
      #4;
      reset = 1'b1;
   endtask

   task automatic run_pass_path(input string tag);
      for (int n = 1; n <= 8; n++) begin
         step((n <= 4) ? 32'((n - 1) * 4) : 32'hC, (n == 5), RA, 32'd0);
         if (n == 7) begin
            n_cmp++;
            if (a_vec !== {1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 32'd7}) begin
               n_fail++;
               $display("FAIL %s_edge7 got %h want %h", tag, a_vec, {1'b0, 1'b0, 2'b00, 1'b1, 32'd0, 32'd7});
            end
         end
      end
      n_cmp++;
      if (a_vec !== {1'b1, 1'b1, 2'b00, 1'b1, 32'd0, 32'd8}) begin
         n_fail++;
         $display("FAIL %s_verdict got %h want %h", tag, a_vec, {1'b1, 1'b1, 2'b00, 1'b1, 32'd0, 32'd8});
      end
   endtask

   task automatic test_reset;
      do_reset();
      n_cmp++;
      if (a_vec !== 69'd0) begin n_fail++; $display("FAIL reset_a got %h want 0", a_vec); end
      n_cmp++;
      if (b_vec !== 69'd0) begin n_fail++; $display("FAIL reset_b got %h want 0", b_vec); end
   endtask

   task automatic test_pass;
      do_reset();
      run_pass_path("pass");
   endtask

   task automatic test_mismatch;
      do_reset();
      for (int n = 1; n <= 8; n++)
         step((n <= 4) ? 32'((n - 1) * 4) : 32'hC, (n <= 3), RA,
              (n == 1) ? 32'd1 : (n == 2) ? 32'd0 : 32'd5);
      n_cmp++;
      if (a_vec !== {1'b1, 1'b0, 2'b01, 1'b1, 32'd5, 32'd8}) begin
         n_fail++;
         $display("FAIL mismatch got %h want %h", a_vec, {1'b1, 1'b0, 2'b01, 1'b1, 32'd5, 32'd8});
      end
   endtask

   task automatic test_no_sig;
      do_reset();
      for (int n = 1; n <= 8; n++)
         step((n <= 4) ? 32'((n - 1) * 4) : 32'hC, (n == 2), RA + 32'd4, 32'd0);
      n_cmp++;
      if (a_vec !== {1'b1, 1'b0, 2'b11, 1'b0, 32'd0, 32'd8}) begin
         n_fail++;
         $display("FAIL no_sig got %h want %h", a_vec, {1'b1, 1'b0, 2'b11, 1'b0, 32'd0, 32'd8});
      end
   endtask

   task automatic test_timeout;
      do_reset();
      for (int n = 1; n <= 20; n++) begin
         step(32'((n - 1) * 4), (n == 18), RA, 32'd7);
         if (n == 15) begin
            n_cmp++;
            if (b_vec !== {1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd15}) begin
               n_fail++;
               $display("FAIL timeout_edge15 got %h want %h", b_vec, {1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd15});
            end
         end
         if (n == 16) begin
            n_cmp++;
            if (b_vec !== {1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'd16}) begin
               n_fail++;
               $display("FAIL timeout_edge16 got %h want %h", b_vec, {1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'd16});
            end
         end
      end
      n_cmp++;
      if (b_vec !== {1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'd16}) begin
         n_fail++;
         $display("FAIL timeout_frozen got %h want %h", b_vec, {1'b1, 1'b0, 2'b10, 1'b0, 32'd0, 32'd16});
      end
   endtask

   // The PC settles at edge 12, so halt falls on edge 16, which is also the timeout edge. The stored
   // signature 9 is wrong, and the correct value 0 arrives only on that final edge.
   task automatic test_same_edge;
      do_reset();
      for (int n = 1; n <= 16; n++)
         step((n <= 12) ? 32'((n - 1) * 4) : 32'd44, (n == 3) || (n == 16), RA,
              (n == 3) ? 32'd9 : 32'd0);
      n_cmp++;
      if (b_vec !== {1'b1, 1'b1, 2'b00, 1'b1, 32'd0, 32'd16}) begin
         n_fail++;
         $display("FAIL same_edge got %h want %h", b_vec, {1'b1, 1'b1, 2'b00, 1'b1, 32'd0, 32'd16});
      end
   endtask

   task automatic test_reset_mid_run;
      do_reset();
      run_pass_path("pre_reset");
      step(32'hC, 1'b0, '0, '0);
      step(32'hC, 1'b0, '0, '0);
      n_cmp++;
      if (a_cnt !== 32'd8) begin n_fail++; $display("FAIL frozen_count got %0d want 8", a_cnt); end
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if (a_vec !== 69'd0) begin n_fail++; $display("FAIL async_reset_a got %h want 0", a_vec); end
      n_cmp++;
      if (b_vec !== 69'd0) begin n_fail++; $display("FAIL async_reset_b got %h want 0", b_vec); end
      do_reset();
      run_pass_path("post_reset");
   endtask

   initial begin
      test_reset();
      test_pass();
      test_mismatch();
      test_no_sig();
      test_timeout();
      test_same_edge();
      test_reset_mid_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
